// File: rtl/forwarding_scoreboard.sv
// Load-use hazard detection and EX-stage forwarding-select generation for a 5-stage pipeline.
// Optional macro FWD_SCOREBOARD_STATS_EN adds stall_count / fwd_count statistics outputs.
module forwarding_scoreboard (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_wsel,
    input  logic        id_regwen,
    input  logic        id_memread,
    input  logic        advance,
    input  logic        flush,
    output logic        stall,
    output logic [1:0]  ex_fwd_a,
    output logic [1:0]  ex_fwd_b
`ifdef FWD_SCOREBOARD_STATS_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] fwd_count
`endif
);

    typedef struct packed {
        logic       valid;
        logic [4:0] wsel;
        logic       regwen;
        logic       memread;
    } slot_t;

    slot_t ex_slot, mem_slot, wb_slot;
    slot_t ex_slot_next;
    logic  bubble;
    logic  issue;
    logic  load_use;
    logic [1:0] fwd_a_next, fwd_b_next;

    function automatic logic produces(input slot_t s, input logic [4:0] r);
        return s.valid && s.regwen && (s.wsel == r) && (r != 5'd0);
    endfunction

    // Nearest producer wins: EX (01) beats MEM (10); anything older reads the register file.
    function automatic logic [1:0] fwd_sel(input slot_t ex_s, input slot_t mem_s,
                                           input logic [4:0] r);
        if (produces(ex_s, r))
            return 2'b01;
        else if (produces(mem_s, r))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        load_use = ex_slot.memread && (produces(ex_slot, id_rs) || produces(ex_slot, id_rt));
        stall    = nRST && id_valid && !flush && load_use;
        bubble   = stall || flush;
        issue    = !bubble && id_valid;

        ex_slot_next = '0;
        if (!bubble) begin
            ex_slot_next.valid   = id_valid;
            ex_slot_next.wsel    = id_wsel;
            ex_slot_next.regwen  = id_regwen;
            ex_slot_next.memread = id_memread;
        end

        fwd_a_next = 2'b00;
        fwd_b_next = 2'b00;
        if (issue) begin
            fwd_a_next = fwd_sel(ex_slot, mem_slot, id_rs);
            fwd_b_next = fwd_sel(ex_slot, mem_slot, id_rt);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ex_slot  <= '0;
            mem_slot <= '0;
            wb_slot  <= '0;
            ex_fwd_a <= 2'b00;
            ex_fwd_b <= 2'b00;
        end else if (advance) begin
            wb_slot  <= mem_slot;
            mem_slot <= ex_slot;
            ex_slot  <= ex_slot_next;
            ex_fwd_a <= fwd_a_next;
            ex_fwd_b <= fwd_b_next;
        end
    end

    // WB is tracked for completeness, but its result reaches EX through the register
    // file (written on the falling edge), so it never feeds a select.
    logic wb_unused;
    assign wb_unused = ^wb_slot;

`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] fwd_inc;
    assign fwd_inc = {31'd0, (fwd_a_next != 2'b00)} + {31'd0, (fwd_b_next != 2'b00)};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_count <= 32'd0;
            fwd_count   <= 32'd0;
        end else if (advance) begin
            if (stall)
                stall_count <= stall_count + 32'd1;
            fwd_count <= fwd_count + fwd_inc;
        end
    end
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed and randomized scoreboard bench for forwarding_scoreboard; expected selects are
// queued when an ID instruction is driven and popped after the clock edge that registers them.
module tb_forwarding_scoreboard;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_wsel = '0;
    logic       id_regwen = 1'b0, id_memread = 1'b0;
    logic       advance = 1'b0, flush = 1'b0;
    logic       stall;
    logic [1:0] ex_fwd_a, ex_fwd_b;
`ifdef FWD_SCOREBOARD_STATS_EN
    logic [31:0] stall_count, fwd_count;
    logic [31:0] m_stall_count = 0, m_fwd_count = 0;
`endif

    forwarding_scoreboard dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_wsel    (id_wsel),
        .id_regwen  (id_regwen),
        .id_memread (id_memread),
        .advance    (advance),
        .flush      (flush),
        .stall      (stall),
        .ex_fwd_a   (ex_fwd_a),
        .ex_fwd_b   (ex_fwd_b)
`ifdef FWD_SCOREBOARD_STATS_EN
        ,
        .stall_count(stall_count),
        .fwd_count  (fwd_count)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;
    logic [3:0] exp_q[$];

    // Reference pipeline for the randomized phase: index 0 = EX, 1 = MEM, 2 = WB.
    logic       m_v[3], m_rw[3], m_mr[3];
    logic [4:0] m_ws[3];
    logic [1:0] m_a, m_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] ws, input logic rw, input logic mr,
                        input logic adv, input logic fl,
                        input logic exp_stall, input logic [1:0] ea, input logic [1:0] eb);
        logic [3:0] e;
        @(negedge CLK);
        id_valid = v; id_rs = rs; id_rt = rt; id_wsel = ws;
        id_regwen = rw; id_memread = mr; advance = adv; flush = fl;
        #1;
        check({tag, "/stall"}, {31'd0, stall}, {31'd0, exp_stall});
        exp_q.push_back({ea, eb});
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            checks++; fails++;
            $display("FAIL %s/queue: observed=empty expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "/fwd_a"}, {30'd0, ex_fwd_a}, {30'd0, e[3:2]});
            check({tag, "/fwd_b"}, {30'd0, ex_fwd_b}, {30'd0, e[1:0]});
        end
        $display("step %s: v=%0b rs=%0d rt=%0d ws=%0d adv=%0b fl=%0b stall=%0b fwd_a=%0b fwd_b=%0b",
                 tag, v, rs, rt, ws, adv, fl, stall, ex_fwd_a, ex_fwd_b);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        check({tag, "/stall"}, {31'd0, stall}, 32'd0);
        check({tag, "/fwd_a"}, {30'd0, ex_fwd_a}, 32'd0);
        check({tag, "/fwd_b"}, {30'd0, ex_fwd_b}, 32'd0);
`ifdef FWD_SCOREBOARD_STATS_EN
        check({tag, "/stall_count"}, stall_count, 32'd0);
        check({tag, "/fwd_count"}, fwd_count, 32'd0);
        m_stall_count = 0;
        m_fwd_count   = 0;
`endif
        @(negedge CLK);
        nRST = 1'b1;
        $display("reset %s: stall=%0b fwd_a=%0b fwd_b=%0b", tag, stall, ex_fwd_a, ex_fwd_b);
    endtask

    function automatic logic m_prod(input int i, input logic [4:0] r);
        return m_v[i] && m_rw[i] && (m_ws[i] == r) && (r != 5'd0);
    endfunction

    function automatic logic [1:0] m_sel(input logic [4:0] r);
        if (m_prod(0, r)) return 2'b01;
        if (m_prod(1, r)) return 2'b10;
        return 2'b00;
    endfunction

    initial begin
        // Reset state
        #12;
        check("reset/stall", {31'd0, stall}, 32'd0);
        check("reset/fwd_a", {30'd0, ex_fwd_a}, 32'd0);
        check("reset/fwd_b", {30'd0, ex_fwd_b}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        // EX-to-EX forward
        step("add3",   1, 5'd1,  5'd2,  5'd3,  1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("sub4",   1, 5'd3,  5'd5,  5'd4,  1, 0, 1, 0, 0, 2'b01, 2'b00);
        // Load-use: one bubble, then MEM forward on both operands
        step("lw2",    1, 5'd9,  5'd0,  5'd2,  1, 1, 1, 0, 0, 2'b00, 2'b00);
        step("use2a",  1, 5'd2,  5'd2,  5'd6,  1, 0, 1, 0, 1, 2'b00, 2'b00);
        step("use2b",  1, 5'd2,  5'd2,  5'd6,  1, 0, 1, 0, 0, 2'b10, 2'b10);
        // Nearest producer wins
        step("addi7a", 1, 5'd0,  5'd0,  5'd7,  1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("addi7b", 1, 5'd0,  5'd0,  5'd7,  1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("or8",    1, 5'd7,  5'd0,  5'd8,  1, 0, 1, 0, 0, 2'b01, 2'b00);
        // Register 0 never matches, even for a load
        step("lw0",    1, 5'd1,  5'd1,  5'd0,  1, 1, 1, 0, 0, 2'b00, 2'b00);
        step("use0",   1, 5'd0,  5'd0,  5'd9,  1, 0, 1, 0, 0, 2'b00, 2'b00);
        // MEM forward, then a WB-only match reads the register file
        step("p10",    1, 5'd1,  5'd1,  5'd10, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("p11",    1, 5'd1,  5'd1,  5'd11, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        step("c1011",  1, 5'd10, 5'd11, 5'd12, 1, 0, 1, 0, 0, 2'b10, 2'b01);
        step("wb10",   1, 5'd10, 5'd1,  5'd14, 1, 0, 1, 0, 0, 2'b00, 2'b00);
        // Flush beats stall
        step("lw13",   1, 5'd1,  5'd1,  5'd13, 1, 1, 1, 0, 0, 2'b00, 2'b00);
        step("flush",  1, 5'd13, 5'd13, 5'd15, 1, 0, 1, 1, 0, 2'b00, 2'b00);
        step("lw16",   1, 5'd13, 5'd1,  5'd16, 1, 1, 1, 0, 0, 2'b10, 2'b00);
        // advance=0 holds slots and selects
        step("hold1",  1, 5'd16, 5'd16, 5'd20, 1, 0, 0, 0, 1, 2'b10, 2'b00);
        step("hold2",  1, 5'd16, 5'd3,  5'd20, 1, 1, 0, 0, 1, 2'b10, 2'b00);
        step("hold3",  1, 5'd16, 5'd16, 5'd20, 1, 0, 0, 1, 0, 2'b10, 2'b00);
        step("stl16",  1, 5'd16, 5'd16, 5'd20, 1, 0, 1, 0, 1, 2'b00, 2'b00);
        step("lw17",   1, 5'd16, 5'd0,  5'd17, 1, 1, 1, 0, 0, 2'b10, 2'b00);
        step("wait17", 1, 5'd17, 5'd2,  5'd21, 1, 0, 0, 0, 1, 2'b10, 2'b00);
        // Reset mid-stall clears everything
        reset_pulse("midrst");
        step("post",   1, 5'd17, 5'd2,  5'd21, 1, 0, 1, 0, 0, 2'b00, 2'b00);

        // Randomized phase against the reference pipeline
        reset_pulse("rndrst");
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_rw[i] = 0; m_mr[i] = 0; m_ws[i] = '0;
        end
        m_a = 2'b00; m_b = 2'b00;
        for (int n = 0; n < 200; n++) begin
            logic       v, rw, mr, adv, fl, es, blk;
            logic [4:0] rs, rt, ws;
            v   = ($urandom_range(0, 9) != 0);
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            ws  = 5'($urandom_range(0, 3));
            rw  = ($urandom_range(0, 4) != 0);
            mr  = ($urandom_range(0, 2) == 0);
            adv = ($urandom_range(0, 4) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            es  = v && !fl && m_mr[0] && (m_prod(0, rs) || m_prod(0, rt));
            blk = es || fl;
            if (adv) begin
                if (!blk && v) begin
                    m_a = m_sel(rs);
                    m_b = m_sel(rt);
                end else begin
                    m_a = 2'b00;
                    m_b = 2'b00;
                end
`ifdef FWD_SCOREBOARD_STATS_EN
                if (es) m_stall_count = m_stall_count + 1;
                m_fwd_count = m_fwd_count + 32'(m_a != 2'b00) + 32'(m_b != 2'b00);
`endif
                m_v[2] = m_v[1]; m_ws[2] = m_ws[1]; m_rw[2] = m_rw[1]; m_mr[2] = m_mr[1];
                m_v[1] = m_v[0]; m_ws[1] = m_ws[0]; m_rw[1] = m_rw[0]; m_mr[1] = m_mr[0];
                if (blk) begin
                    m_v[0] = 0; m_ws[0] = '0; m_rw[0] = 0; m_mr[0] = 0;
                end else begin
                    m_v[0] = v; m_ws[0] = ws; m_rw[0] = rw; m_mr[0] = mr;
                end
            end
            step($sformatf("rnd%0d", n), v, rs, rt, ws, rw, mr, adv, fl, es, m_a, m_b);
`ifdef FWD_SCOREBOARD_STATS_EN
            check($sformatf("rnd%0d/stall_count", n), stall_count, m_stall_count);
            check($sformatf("rnd%0d/fwd_count", n), fwd_count, m_fwd_count);
`endif
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
